// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state encoding and sizing helpers for the arithmetic datapath
package arith_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of a down-counter that must hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial compare/subtract
module div_step #(
  parameter int M = 4
) (
  input  logic [M:0]   i_rem,
  input  logic         i_bit,
  input  logic [M-1:0] i_divisor,
  output logic [M:0]   o_rem,
  output logic         o_qbit
);

  // The top remainder bit is always 0 in practice; carrying it keeps the trial exact.
  logic [M+1:0] w_trial;
  logic [M+1:0] w_dvs;
  logic         w_ge;

  assign w_trial = {i_rem, i_bit};
  assign w_dvs   = {2'b00, i_divisor};
  assign w_ge    = (w_trial >= w_dvs);
  assign o_qbit  = w_ge;
  assign o_rem   = (M+1)'(w_ge ? (w_trial - w_dvs) : w_trial);

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unpipelined restoring divider, one quotient bit per clock
module seq_divider
  import arith_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_data_valid,
  input  logic [N-1:0] i_dividend,
  input  logic [M-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [M-1:0] o_remainder,
  output logic         o_div_by_zero,
  output logic         o_result_valid,
  output logic         o_div_ready
);

  localparam int CW = cnt_width(N);

  state_t        r_state;
  logic [N-1:0]  r_dvd;
  logic [M-1:0]  r_dvs;
  logic [M:0]    r_rem;
  logic [CW-1:0] r_cnt;

  logic [M:0]    w_next_rem;
  logic          w_qbit;
  logic [N-1:0]  w_next_dvd;

  div_step #(.M(M)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[N-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  // Quotient bits replace dividend bits as they are consumed from the MSB end.
  assign w_next_dvd = {r_dvd[N-2:0], w_qbit};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_dvd          <= '0;
      r_dvs          <= '0;
      r_rem          <= '0;
      r_cnt          <= '0;
      o_quotient     <= '0;
      o_remainder    <= '0;
      o_div_by_zero  <= 1'b0;
      o_result_valid <= 1'b0;
      o_div_ready    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_div_ready && i_data_valid) begin
            o_div_ready <= 1'b0;
            r_dvd       <= i_dividend;
            r_dvs       <= i_divisor;
            if (i_divisor != '0) begin
              r_state <= CALC;
              r_rem   <= '0;
              r_cnt   <= CW'(N);
            end else begin
              r_state        <= DONE;
              o_quotient     <= '1;
              o_remainder    <= '0;
              o_div_by_zero  <= 1'b1;
              o_result_valid <= 1'b1;
            end
          end else begin
            o_div_ready <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_next_rem;
          r_dvd <= w_next_dvd;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state        <= DONE;
            o_quotient     <= w_next_dvd;
            o_remainder    <= w_next_rem[M-1:0];
            o_div_by_zero  <= 1'b0;
            o_result_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state        <= IDLE;
          o_result_valid <= 1'b0;
          o_div_ready    <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
